// File: rtl/blackjack_autoplayer.sv
`timescale 1ns/1ps
// Autonomous blackjack player: bets, deals, plays a fixed hit/stand/double
// strategy against the game core's button interface and keeps round statistics.
module blackjack_autoplayer #(
  parameter int unsigned BET           = 4,
  parameter int unsigned HIT_THRESHOLD = 17,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned MAX_ROUNDS    = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] player_current_score,
  input  logic [5:0] dealer_current_score,
  input  logic [4:0] current_coin,
  input  logic       can_split,
  input  logic       Win,
  input  logic       Lose,
  input  logic       Draw,
  output logic       next,
  output logic       hit,
  output logic       stand,
  output logic       double,
  output logic       split,
  output logic       bet_8,
  output logic       bet_4,
  output logic       bet_2,
  output logic       bet_1,
  output logic       busy,
  output logic       halted,
  output logic       timeout_err,
  output logic [7:0] rounds_played,
  output logic [7:0] rounds_won
);

  localparam int unsigned SCORE_W = 6;
  localparam int unsigned BET_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ST_W    = 4;

  localparam logic [ST_W-1:0]    SETTLE_LD = ST_W'(SETTLE);
  localparam logic [BET_W-1:0]   BET_REQ   = BET_W'(BET);
  localparam logic [SCORE_W-1:0] HIT_LIM   = SCORE_W'(HIT_THRESHOLD);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_ROUNDS);
  localparam bit                 MAX_EN    = (MAX_ROUNDS != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_BET, S_COMMIT, S_DEAL, S_DECIDE,
    S_ACT_WAIT, S_RESULT_WAIT, S_RESULT, S_ACK, S_HALT
  } state_t;

  state_t             r_state, w_state_nx;
  logic [ST_W-1:0]    r_st, w_st_nx;
  logic [CNT_W-1:0]   r_tmr, w_tmr_nx;
  logic [CNT_W-1:0]   r_played, w_played_nx;
  logic [CNT_W-1:0]   r_won, w_won_nx;
  logic [BET_W-1:0]   r_bet, w_bet_nx, w_bet_pick;
  logic               r_first, w_first_nx;
  logic               r_terr, w_terr_nx;
  logic               w_next_nx, w_hit_nx, w_stand_nx, w_double_nx;
  logic               w_active_nx, w_result, w_stop, w_st_done;
  logic               w_unused;

  assign w_unused   = can_split;
  assign w_result   = Win | Lose | Draw;
  assign w_st_done  = (r_st == '0);
  assign w_bet_pick = (current_coin < {1'b0, BET_REQ}) ? current_coin[BET_W-1:0] : BET_REQ;
  assign w_stop     = (MAX_EN && (r_played == MAX_CNT)) || (current_coin == '0);

  // Next state, settle/timeout timers, strategy and button pulses
  always_comb begin
    w_state_nx  = r_state;
    w_st_nx     = w_st_done ? r_st : r_st - ST_W'(1);
    w_tmr_nx    = '0;
    w_bet_nx    = r_bet;
    w_first_nx  = r_first;
    w_terr_nx   = r_terr;
    w_played_nx = r_played;
    w_won_nx    = r_won;
    w_next_nx   = 1'b0;
    w_hit_nx    = 1'b0;
    w_stand_nx  = 1'b0;
    w_double_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (current_coin == '0) begin
          w_state_nx = S_HALT;
        end else if (enable) begin
          w_state_nx = S_BET;
          w_bet_nx   = w_bet_pick;
        end
      end
      S_BET: begin
        w_state_nx = S_COMMIT;
        w_next_nx  = 1'b1;
        w_st_nx    = SETTLE_LD;
      end
      S_COMMIT: begin
        if (w_st_done) begin
          w_state_nx = S_DEAL;
          w_next_nx  = 1'b1;
          w_st_nx    = SETTLE_LD;
          w_first_nx = 1'b1;
        end
      end
      S_DEAL: begin
        if (w_st_done) w_state_nx = S_DECIDE;
      end
      S_DECIDE: begin
        if (w_result) begin
          w_state_nx = S_RESULT;
        end else if (player_current_score > 6'd21) begin
          w_state_nx = S_RESULT_WAIT;
        end else if (r_first && (player_current_score == 6'd10 || player_current_score == 6'd11)
                     && (current_coin >= {1'b0, r_bet})) begin
          w_state_nx  = S_RESULT_WAIT;
          w_double_nx = 1'b1;
          w_st_nx     = SETTLE_LD;
        end else if ((player_current_score < HIT_LIM)
                     && !(player_current_score >= 6'd13 && dealer_current_score <= 6'd6)) begin
          w_state_nx = S_ACT_WAIT;
          w_hit_nx   = 1'b1;
          w_st_nx    = SETTLE_LD;
          w_first_nx = 1'b0;
        end else begin
          w_state_nx = S_RESULT_WAIT;
          w_stand_nx = 1'b1;
          w_st_nx    = SETTLE_LD;
        end
      end
      S_ACT_WAIT: begin
        if (w_st_done) w_state_nx = S_DECIDE;
      end
      // Result levels are only trusted once the last pulse has settled
      S_RESULT_WAIT: begin
        if (w_st_done && w_result) begin
          w_state_nx = S_RESULT;
        end else if (r_tmr == TMO_LAST) begin
          w_state_nx = S_HALT;
          w_terr_nx  = 1'b1;
        end else begin
          w_tmr_nx = r_tmr + CNT_W'(1);
        end
      end
      S_RESULT: begin
        w_played_nx = (r_played == '1) ? r_played : r_played + CNT_W'(1);
        if (Win && (r_won != '1)) w_won_nx = r_won + CNT_W'(1);
        w_state_nx = S_ACK;
        w_next_nx  = 1'b1;
        w_st_nx    = SETTLE_LD;
      end
      S_ACK: begin
        if (w_st_done) begin
          if (w_stop) begin
            w_state_nx = S_HALT;
          end else if (enable) begin
            w_state_nx = S_BET;
            w_bet_nx   = w_bet_pick;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      S_HALT: w_state_nx = S_HALT;
      default: w_state_nx = S_IDLE;
    endcase
    w_active_nx = !((w_state_nx == S_IDLE) || (w_state_nx == S_HALT));
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_tmr       <= '0;
      r_played    <= '0;
      r_won       <= '0;
      r_bet       <= '0;
      r_first     <= 1'b0;
      r_terr      <= 1'b0;
      next        <= 1'b0;
      hit         <= 1'b0;
      stand       <= 1'b0;
      double      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      {bet_8, bet_4, bet_2, bet_1} <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_st        <= w_st_nx;
      r_tmr       <= w_tmr_nx;
      r_played    <= w_played_nx;
      r_won       <= w_won_nx;
      r_bet       <= w_bet_nx;
      r_first     <= w_first_nx;
      r_terr      <= w_terr_nx;
      next        <= w_next_nx;
      hit         <= w_hit_nx;
      stand       <= w_stand_nx;
      double      <= w_double_nx;
      busy        <= w_active_nx;
      halted      <= (w_state_nx == S_HALT);
      {bet_8, bet_4, bet_2, bet_1} <= w_active_nx ? w_bet_nx : '0;
    end
  end

  assign split         = 1'b0;
  assign timeout_err   = r_terr;
  assign rounds_played = r_played;
  assign rounds_won    = r_won;

endmodule
